// File: rtl/ddr3_cpu_req_queue.sv
// ddr3_cpu_req_queue
// In-order CPU request buffer that feeds the DDR3 controller over a
// valid/ready handshake. Everything runs on cpu_clk.
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. The upstream ready (cpu_req_ready) depends only on
// the registered occupancy, so it has no combinational path from
// cont_req_ready. The downstream payload is held stable while
// cont_req_valid is high and cont_req_ready is low.
//
// Occupancy state is visible on q_empty / q_full / q_count:
// EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count == DEPTH).
//
// Optional feature macro: DDR3_REQ_STATS_EN. When it is defined, three
// 16-bit saturating statistics counters are built. When it is undefined,
// the statistics ports read 0.
module ddr3_cpu_req_queue #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                       cpu_clk,
  input  logic                       reset,
  input  logic                       cpu_req_valid,
  output logic                       cpu_req_ready,
  input  logic                       cpu_req_wr,
  input  logic [ADDR_W-1:0]          cpu_req_addr,
  input  logic [DATA_W-1:0]          cpu_req_wdata,
  output logic                       cont_req_valid,
  input  logic                       cont_req_ready,
  output logic                       cont_req_wr,
  output logic [ADDR_W-1:0]          cont_req_addr,
  output logic [DATA_W-1:0]          cont_req_wdata,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic                       q_empty,
  output logic                       q_overflow,
  output logic [15:0]                stat_rd_cnt,
  output logic [15:0]                stat_wr_cnt,
  output logic [15:0]                stat_stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not reset; only the pointers and the count define validity.
  logic              mem_wr    [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  assign q_full         = (q_count == CNT_W'(DEPTH));
  assign q_empty        = (q_count == '0);
  assign cpu_req_ready  = !q_full;
  assign cont_req_valid = !q_empty;

  assign push = cpu_req_valid && cpu_req_ready;
  assign pop  = cont_req_valid && cont_req_ready;

  // The head entry is read combinationally at rd_ptr.
  assign cont_req_wr    = mem_wr[rd_ptr];
  assign cont_req_addr  = mem_addr[rd_ptr];
  assign cont_req_wdata = mem_wdata[rd_ptr];

  // Write accepted requests into the array; ignore pushes in the reset cycle.
  always_ff @(posedge cpu_clk) begin
    if (!reset && push) begin
      mem_wr[wr_ptr]    <= cpu_req_wr;
      mem_addr[wr_ptr]  <= cpu_req_addr;
      mem_wdata[wr_ptr] <= cpu_req_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy separately.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Sticky flag: the CPU presented a request while the queue was full.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      q_overflow <= 1'b0;
    end else if (cpu_req_valid && q_full) begin
      q_overflow <= 1'b1;
    end
  end

`ifdef DDR3_REQ_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating counters for accepted reads, accepted writes and head stalls.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      rd_cnt_r    <= '0;
      wr_cnt_r    <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (push && !cpu_req_wr && rd_cnt_r != 16'hFFFF) rd_cnt_r <= rd_cnt_r + 16'd1;
      if (push &&  cpu_req_wr && wr_cnt_r != 16'hFFFF) wr_cnt_r <= wr_cnt_r + 16'd1;
      if (cont_req_valid && !cont_req_ready && stall_cnt_r != 16'hFFFF)
        stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign stat_rd_cnt    = rd_cnt_r;
  assign stat_wr_cnt    = wr_cnt_r;
  assign stat_stall_cnt = stall_cnt_r;
`else
  assign stat_rd_cnt    = 16'd0;
  assign stat_wr_cnt    = 16'd0;
  assign stat_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ddr3_cpu_req_queue.sv
// Bench for ddr3_cpu_req_queue: directed vectors, a queue-based reference
// model, a per-cycle compare process and literal expectations.
module tb_ddr3_cpu_req_queue;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int E_W    = 1 + ADDR_W + DATA_W;

  logic                   cpu_clk;
  logic                   reset;
  logic                   cpu_req_valid;
  logic                   cpu_req_ready;
  logic                   cpu_req_wr;
  logic [ADDR_W-1:0]      cpu_req_addr;
  logic [DATA_W-1:0]      cpu_req_wdata;
  logic                   cont_req_valid;
  logic                   cont_req_ready;
  logic                   cont_req_wr;
  logic [ADDR_W-1:0]      cont_req_addr;
  logic [DATA_W-1:0]      cont_req_wdata;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   q_overflow;
  logic [15:0]            stat_rd_cnt;
  logic [15:0]            stat_wr_cnt;
  logic [15:0]            stat_stall_cnt;

  ddr3_cpu_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .cpu_clk        (cpu_clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_wr     (cpu_req_wr),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cont_req_valid (cont_req_valid),
    .cont_req_ready (cont_req_ready),
    .cont_req_wr    (cont_req_wr),
    .cont_req_addr  (cont_req_addr),
    .cont_req_wdata (cont_req_wdata),
    .q_count        (q_count),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .q_overflow     (q_overflow),
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  // ---------------- clock ----------------
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int max_cnt = 0;

  // Reference model state
  logic [E_W-1:0]    exp_q[$];
  bit                m_ovf;
  int                m_rd, m_wr, m_stall;
  logic [ADDR_W-1:0] got_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit rdy);
    cpu_req_valid  = v;
    cpu_req_wr     = wr;
    cpu_req_addr   = a;
    cpu_req_wdata  = d;
    cont_req_ready = rdy;
  endtask

  // Reference model: a plain queue updated from the inputs at each edge.
  initial begin
    bit m_push, m_pop, m_valid;
    m_ovf = 0; m_rd = 0; m_wr = 0; m_stall = 0;
    forever begin
      @(posedge cpu_clk);
      if (reset) begin
        exp_q.delete();
        m_ovf = 0; m_rd = 0; m_wr = 0; m_stall = 0;
      end else begin
        m_valid = (exp_q.size() > 0);
        m_push  = cpu_req_valid && (exp_q.size() < DEPTH);
        m_pop   = cont_req_ready && m_valid;
        if (cpu_req_valid && exp_q.size() == DEPTH) m_ovf = 1;
        if (m_valid && !cont_req_ready && m_stall < 16'hFFFF) m_stall++;
        if (m_push && !cpu_req_wr && m_rd < 16'hFFFF) m_rd++;
        if (m_push &&  cpu_req_wr && m_wr < 16'hFFFF) m_wr++;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({cpu_req_wr, cpu_req_addr, cpu_req_wdata});
      end
    end
  end

  // Compare process: every negedge, DUT outputs versus the model.
  initial begin
    int sz;
    logic [E_W-1:0] h;
    forever begin
      @(negedge cpu_clk);
      if (cmp_en) begin
        sz = exp_q.size();
        if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
        check("q_count",        q_count,        sz);
        check("q_empty",        q_empty,        sz == 0);
        check("q_full",         q_full,         sz == DEPTH);
        check("cpu_req_ready",  cpu_req_ready,  sz != DEPTH);
        check("cont_req_valid", cont_req_valid, sz != 0);
        check("q_overflow",     q_overflow,     m_ovf);
        if (sz != 0) begin
          h = exp_q[0];
          check("cont_req_wr",    cont_req_wr,    h[E_W-1]);
          check("cont_req_addr",  cont_req_addr,  h[DATA_W+ADDR_W-1:DATA_W]);
          check("cont_req_wdata", cont_req_wdata, h[DATA_W-1:0]);
        end
`ifdef DDR3_REQ_STATS_EN
        check("stat_rd_cnt",    stat_rd_cnt,    m_rd);
        check("stat_wr_cnt",    stat_wr_cnt,    m_wr);
        check("stat_stall_cnt", stat_stall_cnt, m_stall);
`else
        check("stat_rd_cnt",    stat_rd_cnt,    0);
        check("stat_wr_cnt",    stat_wr_cnt,    0);
        check("stat_stall_cnt", stat_stall_cnt, 0);
`endif
        if (cont_req_valid && cont_req_ready) got_q.push_back(cont_req_addr);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int sent, cyc;
    bit acc;
    reset = 1'b1;
    drive(0, 0, '0, '0, 0);
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_count", q_count, 0);
    check("rst_empty", q_empty, 1);
    check("rst_full",  q_full, 0);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_valid", cont_req_valid, 0);
    check("rst_ovf",   q_overflow, 0);

    // Single write, then pop
    drive(1, 1, 28'h0000123, 64'hDEADBEEF_CAFEF00D, 0);
    step();
    drive(0, 0, '0, '0, 0);
    check("single_valid", cont_req_valid, 1);
    check("single_wr",    cont_req_wr, 1);
    check("single_addr",  cont_req_addr, 28'h0000123);
    check("single_wdata", cont_req_wdata, 64'hDEADBEEF_CAFEF00D);
    check("single_count", q_count, 1);
    cont_req_ready = 1;
    step();
    cont_req_ready = 0;
    check("single_empty", q_empty, 1);

    // Fill with 8 alternating requests, then overflow attempt
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], ADDR_W'(i), 64'h1000 + 64'(i), 0);
      step();
    end
    drive(0, 0, '0, '0, 0);
    check("fill_full",  q_full, 1);
    check("fill_ready", cpu_req_ready, 0);
    check("fill_ovf0",  q_overflow, 0);
    drive(1, 1, 28'h99, 64'h99, 0);
    step();
    drive(0, 0, '0, '0, 0);
    check("ovf_set",   q_overflow, 1);
    check("ovf_count", q_count, 8);
    cont_req_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain_addr", cont_req_addr, i);
      check("drain_wr",   cont_req_wr, i[0]);
      step();
    end
    cont_req_ready = 0;
    check("drain_empty", q_empty, 1);
    check("ovf_sticky",  q_overflow, 1);

    // Stream 20 requests with ready toggling every cycle
    got_q.delete();
    max_cnt = 0;
    sent = 0;
    cyc = 0;
    while (sent < 20 && cyc < 200) begin
      drive(1, sent[0], ADDR_W'(200 + sent), 64'(sent), cyc[0]);
      acc = cpu_req_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    check("stream_sent", sent, 20);
    drive(0, 0, '0, '0, 1);
    cyc = 0;
    while (!q_empty && cyc < 40) begin
      step();
      cyc++;
    end
    cont_req_ready = 0;
    check("stream_drained", q_empty, 1);
    check("stream_npop", got_q.size(), 20);
    for (int k = 0; k < 20 && k < got_q.size(); k++)
      check("stream_order", got_q[k], 200 + k);
    check("stream_max", max_cnt <= DEPTH, 1);

    // Simultaneous push and pop at count 3
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, ADDR_W'(8'h30 + i), 64'(i), 0);
      step();
    end
    drive(1, 1, 28'h33, 64'h33, 1);
    check("pp_count_before", q_count, 3);
    check("pp_head_before",  cont_req_addr, 28'h30);
    step();
    drive(0, 0, '0, '0, 0);
    check("pp_count_after", q_count, 3);
    check("pp_head_after",  cont_req_addr, 28'h31);

    // Reset with 5 entries and a push active
    drive(1, 0, 28'h34, 64'h34, 0);
    step();
    drive(1, 0, 28'h35, 64'h35, 0);
    step();
    check("pre_rst_count", q_count, 5);
    drive(1, 1, 28'h77, 64'h77, 0);
    reset = 1;
    step();
    reset = 0;
    drive(0, 0, '0, '0, 0);
    check("mid_rst_count", q_count, 0);
    check("mid_rst_valid", cont_req_valid, 0);
    check("mid_rst_ovf",   q_overflow, 0);
    step();
    step();
    check("mid_rst_absent", q_empty, 1);

    // Statistics: 3 reads, 2 writes, then 4 stalled cycles
    for (int i = 0; i < 5; i++) begin
      drive(1, i[0], ADDR_W'(8'h50 + i), 64'(i), 1);
      step();
    end
    drive(0, 0, '0, '0, 0);
    repeat (4) step();
`ifdef DDR3_REQ_STATS_EN
    check("stats_rd",    stat_rd_cnt, 3);
    check("stats_wr",    stat_wr_cnt, 2);
    check("stats_stall", stat_stall_cnt, 4);
`else
    check("stats_rd",    stat_rd_cnt, 0);
    check("stats_wr",    stat_wr_cnt, 0);
    check("stats_stall", stat_stall_cnt, 0);
`endif
    check("stats_head", cont_req_addr, 28'h54);
    cont_req_ready = 1;
    step();
    cont_req_ready = 0;
    check("final_empty", q_empty, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_cpu_req_queue.md
# ddr3_cpu_req_queue

CPU-side request queue that sits directly upstream of the DDR3 memory controller. It buffers read and write requests from the CPU and presents them in order to the controller over a valid/ready handshake. This decouples CPU issue timing from controller back-pressure during refresh, activate and precharge. It runs entirely in the `cpu_clk` domain and has no DDR3 pin-level behaviour.

## Interface
Parameters:
- `ADDR_W`, 28: request address width (bank/row/column packed by the controller).
- `DATA_W`, 64: write data width per request.
- `DEPTH`, 8: queue entries; power of two, ≥ 2.

Ports:
- `cpu_clk` in 1: the only clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_req_valid` in 1: CPU presents a request.
- `cpu_req_ready` out 1: queue can accept; equals `!q_full`.
- `cpu_req_wr` in 1: 1 = write, 0 = read.
- `cpu_req_addr` in ADDR_W: request address.
- `cpu_req_wdata` in DATA_W: write data; stored for reads but ignored downstream.
- `cont_req_valid` out 1: head entry available to the controller; equals `!q_empty`.
- `cont_req_ready` in 1: controller consumes the head entry.
- `cont_req_wr` out 1: head entry command.
- `cont_req_addr` out ADDR_W: head entry address.
- `cont_req_wdata` out DATA_W: head entry data.
- `q_count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `q_full` out 1: `q_count == DEPTH`.
- `q_empty` out 1: `q_count == 0`.
- `q_overflow` out 1: sticky protocol-violation flag.
- `stat_rd_cnt`, `stat_wr_cnt`, `stat_stall_cnt` out 16 each: statistics; see Configuration.

## Operation
- Push occurs when `cpu_req_valid && cpu_req_ready`. The entry {wr, addr, wdata} is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop occurs when `cont_req_valid && cont_req_ready`. `rd_ptr` increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate `q_count` register.
- Occupancy states:
  - EMPTY (count 0) → PARTIAL on push.
  - PARTIAL → EMPTY on a pop that leaves count 0.
  - PARTIAL → FULL on a push that makes count DEPTH.
  - FULL → PARTIAL on pop.
- Count update per cycle: push only → +1; pop only → −1; push and pop together → unchanged, with both pointers advancing.
- Ordering is strict FIFO. Requests are never reordered or merged.
- `cpu_req_ready` depends only on `q_full`, never on `cont_req_ready`. When FULL, a same-cycle pop does not enable a push.
- Push and pop in the same cycle are legal only in PARTIAL. In EMPTY, `cont_req_valid` = 0, so no pop occurs.
- `cont_req_*` payload is the array entry at `rd_ptr`, read combinationally. It is meaningful only while `cont_req_valid` = 1, and it must be held stable while valid is high and ready is low.
- Overflow: `q_overflow` sets when `cpu_req_valid` = 1 while `q_full` = 1. The request is dropped, and the flag stays set until `reset`.
- Reset values: `q_count` = 0, pointers = 0, `q_empty` = 1, `q_full` = 0, `cpu_req_ready` = 1, `cont_req_valid` = 0, `q_overflow` = 0, statistics = 0. Array contents are not reset.
- Reset mid-operation flushes all entries. A push or pop in the reset cycle is ignored.

## Timing
- Push to controller visibility: a request accepted at edge N appears with `cont_req_valid` = 1 after edge N, so it is sampleable by the controller at edge N+1. Minimum latency is 1 cycle.
- A pop at edge N presents the next entry after edge N; back-to-back pops deliver 1 request per cycle.
- `q_full` and `cpu_req_ready` update after the edge that changes the count. There are no combinational paths from `cont_req_ready` to `cpu_req_ready`.
- Sustained throughput is 1 request per cycle in each direction while in PARTIAL.

## Configuration
- `DDR3_REQ_STATS_EN`: when defined, the three statistics counters are implemented as 16-bit saturating counters that stop at 0xFFFF:
  - `stat_rd_cnt` increments on each accepted read push.
  - `stat_wr_cnt` increments on each accepted write push.
  - `stat_stall_cnt` increments each cycle with `cont_req_valid` = 1 and `cont_req_ready` = 0.
- When undefined, the ports remain present and are tied to 0, and no counter logic is synthesised.

## Test plan
- Reset, then a single write (addr 0x0000123, wdata 0xDEADBEEF_CAFEF00D) with `cont_req_ready` = 0 → next cycle `cont_req_valid` = 1, payload matches, `q_count` = 1; on ready = 1 it pops and `q_empty` = 1.
- Push 8 alternating rd/wr requests (addr 0..7) with ready = 0 → `q_full` = 1 and `cpu_req_ready` = 0. A 9th valid sets `q_overflow` = 1 and the request is dropped. Draining yields addr 0..7 in order.
- With DEPTH = 8, stream 20 requests with ready toggling every cycle → all 20 emerge in order across pointer wrap, and `q_count` never exceeds 8.
- With count = 3, push and pop in the same cycle → `q_count` stays 3 and the popped entry is the oldest.
- Assert `reset` with 5 entries queued and a push active → next cycle `q_count` = 0, `cont_req_valid` = 0, `q_overflow` = 0; the pushed request is absent.
- With `DDR3_REQ_STATS_EN` defined: 3 reads, 2 writes, and ready held low 4 cycles while valid → `stat_rd_cnt` = 3, `stat_wr_cnt` = 2, `stat_stall_cnt` = 4. With the macro undefined, all three read 0.
